// File: rtl/vdp_pkg.sv
// Shared types for the video display pipeline draw side.
//   feeder_state_e : tile_line_feeder control states
//   pattern_mode_e : pixel pattern selected by tile_line_feeder.mode
package vdp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feeder_state_e;

  typedef enum logic [1:0] {
    RAMP    = 2'd0,
    CHECKER = 2'd1,
    ROW     = 2'd2,
    XOR     = 2'd3
  } pattern_mode_e;

endpackage

// File: rtl/tile_pattern_gen.sv
// Combinational source-pattern lookup for one pixel.
//   sx_i   : source x (already scrolled, wraps mod 2^CORDW)
//   sy_i   : source y (already scrolled, wraps mod 2^CORDW)
//   mode_i : pattern select
//   pix_o  : PIXW-bit palette index
module tile_pattern_gen
  import vdp_pkg::*;
#(
  parameter int CORDW = 11,
  parameter int PIXW  = 8
) (
  input  logic [CORDW-1:0] sx_i,
  input  logic [CORDW-1:0] sy_i,
  input  pattern_mode_e    mode_i,
  output logic [PIXW-1:0]  pix_o
);

  always_comb begin
    pix_o = '0;
    unique case (mode_i)
      RAMP:    pix_o = PIXW'(sx_i);
      // 8x8 cells: bit 3 of each coordinate selects the cell parity
      CHECKER: pix_o = (sx_i[3] ^ sy_i[3]) ? PIXW'(32'hFF) : '0;
      ROW:     pix_o = PIXW'(sy_i);
      XOR:     pix_o = PIXW'(sx_i ^ sy_i);
      default: pix_o = '0;
    endcase
  end

endmodule

// File: rtl/tile_line_feeder.sv
// Per-scanline tile word source for the draw side.
// On line_start it latches the window/scroll/mode parameters and streams
// PIX_PER_WORD-pixel words covering the window, with edge valid masks,
// under a valid/ready handshake.
//   clk_draw, rst_draw     : clock, synchronous active-high reset
//   line_start             : begin (or restart) a line with the current inputs
//   line_y, scroll_x/_y    : source coordinate inputs
//   win_start, win_end     : visible window [win_start, min(win_end, LINE_W))
//   mode                   : pattern select (vdp_pkg::pattern_mode_e)
//   out_valid / out_ready  : word handshake
//   tile_pixels            : pixel i in bits [i*PIXW +: PIXW]
//   tile_valid_mask        : bit i set when pixel i is inside the window
//   tile_x                 : screen x of pixel 0
//   busy, line_done        : line in progress, one-cycle completion pulse
module tile_line_feeder
  import vdp_pkg::*;
#(
  parameter int CORDW        = 11,
  parameter int PIX_PER_WORD = 4,
  parameter int PIXW         = 8,
  parameter int LINE_W       = 640
) (
  input  logic                         clk_draw,
  input  logic                         rst_draw,
  input  logic                         line_start,
  input  logic [CORDW-1:0]             line_y,
  input  logic [CORDW-1:0]             scroll_x,
  input  logic [CORDW-1:0]             scroll_y,
  input  logic [CORDW-1:0]             win_start,
  input  logic [CORDW-1:0]             win_end,
  input  logic [1:0]                   mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PIX_PER_WORD*PIXW-1:0] tile_pixels,
  output logic [PIX_PER_WORD-1:0]      tile_valid_mask,
  output logic [CORDW-1:0]             tile_x,
  output logic                         busy,
  output logic                         line_done
);

  localparam logic [CORDW-1:0] ALIGN_MASK = ~CORDW'(PIX_PER_WORD - 1);
  localparam logic [CORDW-1:0] LINE_W_C   = CORDW'(LINE_W);
  localparam logic [CORDW-1:0] STEP       = CORDW'(PIX_PER_WORD);

  feeder_state_e state_q, state_d;

  // Parameters captured at line_start
  logic [CORDW-1:0] scroll_x_q, sy_q, win_start_q, end_q, last_tx_q;
  pattern_mode_e    mode_q;

  // Output word registers
  logic [CORDW-1:0]             tile_x_q;
  logic [PIX_PER_WORD*PIXW-1:0] pix_q;
  logic [PIX_PER_WORD-1:0]      mask_q;

  logic [CORDW-1:0] eff_end, sy_in;
  logic             empty_win, load_word;

  assign eff_end   = (win_end < LINE_W_C) ? win_end : LINE_W_C;
  assign empty_win = (win_start >= eff_end);
  assign sy_in     = line_y + scroll_y;

  // The next word is built either from the raw inputs (first word of a new
  // line) or from the latched parameters (subsequent words).
  logic [CORDW-1:0]             src_tx, src_scroll, src_sy, src_ws, src_end;
  pattern_mode_e                src_mode;
  logic [PIX_PER_WORD*PIXW-1:0] pix_d;
  logic [PIX_PER_WORD-1:0]      mask_d;

  assign src_tx     = line_start ? (win_start & ALIGN_MASK) : (tile_x_q + STEP);
  assign src_scroll = line_start ? scroll_x  : scroll_x_q;
  assign src_sy     = line_start ? sy_in     : sy_q;
  assign src_ws     = line_start ? win_start : win_start_q;
  assign src_end    = line_start ? eff_end   : end_q;
  assign src_mode   = line_start ? pattern_mode_e'(mode) : mode_q;

  for (genvar i = 0; i < PIX_PER_WORD; i++) begin : g_pix
    logic [CORDW-1:0] x, sx;
    assign x  = src_tx + CORDW'(i);
    assign sx = x + src_scroll;
    tile_pattern_gen #(.CORDW(CORDW), .PIXW(PIXW)) u_gen (
      .sx_i   (sx),
      .sy_i   (src_sy),
      .mode_i (src_mode),
      .pix_o  (pix_d[i*PIXW +: PIXW])
    );
    assign mask_d[i] = (x >= src_ws) && (x < src_end);
  end

  // line_start takes priority everywhere, so a restart landing on the final
  // handshake never enters DONE and the old line reports no completion.
  always_comb begin
    state_d   = state_q;
    load_word = 1'b0;
    if (line_start) begin
      state_d   = empty_win ? DONE : RUN;
      load_word = !empty_win;
    end else begin
      unique case (state_q)
        RUN: begin
          if (out_ready) begin
            if (tile_x_q >= last_tx_q) state_d = DONE;
            else                       load_word = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_draw) begin
    if (rst_draw) begin
      state_q  <= IDLE;
      tile_x_q <= '0;
      pix_q    <= '0;
      mask_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_word) begin
        tile_x_q <= src_tx;
        pix_q    <= pix_d;
        mask_q   <= mask_d;
      end
    end
  end

  always_ff @(posedge clk_draw) begin
    if (line_start) begin
      scroll_x_q  <= scroll_x;
      sy_q        <= sy_in;
      win_start_q <= win_start;
      end_q       <= eff_end;
      last_tx_q   <= (eff_end - CORDW'(1)) & ALIGN_MASK;
      mode_q      <= pattern_mode_e'(mode);
    end
  end

  assign out_valid       = (state_q == RUN);
  assign busy            = (state_q != IDLE);
  assign line_done       = (state_q == DONE);
  assign tile_x          = tile_x_q;
  assign tile_pixels     = pix_q;
  assign tile_valid_mask = mask_q;

endmodule

// File: tb/tb_tile_line_feeder.sv
module tb_tile_line_feeder;

  localparam int CORDW = 11;
  localparam int PPW   = 4;
  localparam int PIXW  = 8;
  localparam int LW    = 640;

  logic                  clk_draw = 1'b0;
  logic                  rst_draw = 1'b1;
  logic                  line_start = 1'b0;
  logic [CORDW-1:0]      line_y = '0, scroll_x = '0, scroll_y = '0;
  logic [CORDW-1:0]      win_start = '0, win_end = '0;
  logic [1:0]            mode = '0;
  logic                  out_valid, out_ready = 1'b0;
  logic [PPW*PIXW-1:0]   tile_pixels;
  logic [PPW-1:0]        tile_valid_mask;
  logic [CORDW-1:0]      tile_x;
  logic                  busy, line_done;

  int errors = 0;
  int checks = 0;

  tile_line_feeder #(.CORDW(CORDW), .PIX_PER_WORD(PPW), .PIXW(PIXW), .LINE_W(LW)) dut (
    .clk_draw        (clk_draw),
    .rst_draw        (rst_draw),
    .line_start      (line_start),
    .line_y          (line_y),
    .scroll_x        (scroll_x),
    .scroll_y        (scroll_y),
    .win_start       (win_start),
    .win_end         (win_end),
    .mode            (mode),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .tile_pixels     (tile_pixels),
    .tile_valid_mask (tile_valid_mask),
    .tile_x          (tile_x),
    .busy            (busy),
    .line_done       (line_done)
  );

  always #5 clk_draw = ~clk_draw;

  typedef struct {
    int                  tx;
    logic [PPW*PIXW-1:0] pix;
    logic [PPW-1:0]      mask;
  } word_t;

  task automatic tick();
    @(posedge clk_draw);
    #1;
  endtask

  // Reference pattern from the plain arithmetic rules
  function automatic int pattern(input int sx, input int sy, input int md);
    int v;
    case (md)
      0: v = sx;
      1: v = (((sx / 8) % 2) != ((sy / 8) % 2)) ? 255 : 0;
      2: v = sy;
      default: v = sx ^ sy;
    endcase
    return v % (1 << PIXW);
  endfunction

  task automatic build_words(input int ly, input int scx, input int scy, input int ws,
                             input int we, input int md, output word_t q[$]);
    int e, sy;
    q = {};
    e  = (we < LW) ? we : LW;
    sy = (ly + scy) % (1 << CORDW);
    if (ws >= e) return;
    for (int k = ws / PPW; k <= (e - 1) / PPW; k++) begin
      word_t w;
      w.tx = k * PPW;
      w.pix = '0;
      w.mask = '0;
      for (int i = 0; i < PPW; i++) begin
        int x, sx;
        x  = w.tx + i;
        sx = (x + scx) % (1 << CORDW);
        w.pix[i*PIXW +: PIXW] = PIXW'(pattern(sx, sy, md));
        w.mask[i] = (x >= ws) && (x < e);
      end
      q.push_back(w);
    end
  endtask

  // Issues line_start, then checks every cycle until line_done (or until
  // abort_after cycles have been observed). rmode: 0 ready, 1 random,
  // 2 stall 3 cycles while word 2 is presented. exp_done < 0: no cycle check.
  task automatic run_line(input string nm, input int ly, input int scx, input int scy,
                          input int ws, input int we, input int md, input int rmode,
                          input int abort_after, input int exp_done);
    word_t q[$];
    int total, popped, stall_w2, cyc;
    bit ready, finished;
    build_words(ly, scx, scy, ws, we, md, q);
    total = q.size();
    popped = 0; stall_w2 = 0; finished = 0;
    line_y = CORDW'(ly); scroll_x = CORDW'(scx); scroll_y = CORDW'(scy);
    win_start = CORDW'(ws); win_end = CORDW'(we); mode = 2'(md);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    cyc = 1;
    while (cyc < 4000 && !finished) begin
      if (abort_after > 0 && cyc > abort_after) return;
      case (rmode)
        0: ready = 1'b1;
        1: ready = ($urandom_range(0, 3) != 0);
        default: begin
          ready = !(popped == 2 && stall_w2 < 3);
          if (!ready) stall_w2++;
        end
      endcase
      if (q.size() > 0) begin
        checks++;
        if (out_valid !== 1'b1 || tile_x !== CORDW'(q[0].tx) ||
            tile_pixels !== q[0].pix || tile_valid_mask !== q[0].mask) begin
          errors++;
          $display("FAIL %s word%0d cyc%0d: got v=%b x=%0d pix=%h m=%b, want v=1 x=%0d pix=%h m=%b",
                   nm, popped, cyc, out_valid, tile_x, tile_pixels, tile_valid_mask,
                   q[0].tx, q[0].pix, q[0].mask);
        end
        checks++;
        if (line_done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s status cyc%0d: got done=%b busy=%b, want done=0 busy=1",
                   nm, cyc, line_done, busy);
        end
        if (ready) begin
          void'(q.pop_front());
          popped++;
        end
      end else begin
        checks++;
        if (line_done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s done cyc%0d: got done=%b v=%b busy=%b, want 1 0 1",
                   nm, cyc, line_done, out_valid, busy);
        end
        if (exp_done >= 0) begin
          checks++;
          if (cyc != exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d, want %0d", nm, cyc, exp_done);
          end
        end
        finished = 1;
      end
      out_ready = ready;
      tick();
      cyc++;
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL %s timeout: popped %0d of %0d words, want line_done", nm, popped, total);
    end else begin
      checks++;
      if (line_done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s after_done: got done=%b busy=%b v=%b, want 0 0 0",
                 nm, line_done, busy, out_valid);
      end
    end
  endtask

  task automatic check_all_zero(input string nm);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || line_done !== 1'b0 ||
        tile_pixels !== '0 || tile_valid_mask !== '0 || tile_x !== '0) begin
      errors++;
      $display("FAIL %s: got v=%b busy=%b done=%b pix=%h m=%b x=%0d, want all 0",
               nm, out_valid, busy, line_done, tile_pixels, tile_valid_mask, tile_x);
    end
  endtask

  task automatic test_reset();
    rst_draw = 1'b1;
    line_start = 1'b1;
    win_start = '0; win_end = CORDW'(640);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all_zero("reset_hold");
    end
    rst_draw = 1'b0;
    line_start = 1'b0;
    tick();
    check_all_zero("reset_release");
    tick();
    check_all_zero("reset_idle");
  endtask

  task automatic test_full_line();
    run_line("full_line", 0, 0, 0, 0, 640, 0, 0, 0, 161);
  endtask

  task automatic test_partial();
    run_line("partial", 3, 0, 0, 5, 18, 0, 0, 0, 5);
    run_line("partial_m3", 7, 2, 1, 5, 18, 3, 0, 0, 5);
  endtask

  task automatic test_backpressure();
    run_line("backpressure", 0, 0, 0, 0, 640, 0, 2, 0, 164);
  endtask

  task automatic test_restart();
    run_line("restart_first", 9, 0, 0, 0, 640, 0, 0, 49, -1);
    run_line("restart_second", 0, 6, 0, 0, 640, 1, 0, 0, 161);
  endtask

  task automatic test_empty();
    run_line("empty_eq", 0, 0, 0, 20, 20, 0, 0, 0, 1);
    run_line("empty_past_line", 0, 0, 0, 700, 800, 0, 0, 0, 1);
  endtask

  task automatic test_reset_midline();
    out_ready = 1'b1;
    run_line("midline_first", 4, 0, 0, 0, 640, 2, 0, 10, -1);
    rst_draw = 1'b1;
    tick();
    check_all_zero("midline_reset");
    rst_draw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all_zero("midline_after");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int ws, we;
      ws = $urandom_range(0, 660);
      we = $urandom_range(0, 2047);
      if (n == 0) we = ws + $urandom_range(1, 9);
      run_line("random", $urandom_range(0, 2047), $urandom_range(0, 2047),
               $urandom_range(0, 2047), ws, we, $urandom_range(0, 3), 1, 0, -1);
    end
  endtask

  task automatic test_back_to_back();
    run_line("b2b_a", 1, 100, 0, 600, 650, 0, 0, 0, 11);
    run_line("b2b_b", 2, 0, 2040, 630, 640, 3, 1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_partial();
    test_backpressure();
    test_restart();
    test_empty();
    test_reset_midline();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
